// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the EX-stage ALU: operand forwarding, load-use
// bubbles and a bubble counter. Optional macro IDEX_FWD_EN enables EX/MEM and MEM/WB forwarding.
module id_ex_stage #(
    parameter int ALUOP_W = 5,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               id_valid,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    input  logic [31:0]        id_rs_data,
    input  logic [31:0]        id_rt_data,
    input  logic [31:0]        id_imm,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic               id_alusrc,
    input  logic               id_regwrite,
    input  logic               id_memread,
    input  logic               id_memwrite,
    input  logic               exmem_regwrite,
    input  logic [4:0]         exmem_rd,
    input  logic [31:0]        exmem_result,
    input  logic               memwb_regwrite,
    input  logic [4:0]         memwb_rd,
    input  logic [31:0]        memwb_result,
    input  logic               ext_hold,
    input  logic               flush,
    output logic               id_stall,
    output logic               ex_valid,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [31:0]        ex_store_data,
    output logic [4:0]         ex_rd,
    output logic               ex_regwrite,
    output logic               ex_memread,
    output logic               ex_memwrite,
    output logic [CNT_W-1:0]   bubble_cnt
);

    // Handshake: ID offers an instruction with id_valid=1 and must keep presenting it
    // unchanged while id_stall=1; it is consumed at the first edge with id_stall=0.

    logic               valid_q, valid_d;
    logic [4:0]         rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [31:0]        rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
    logic [ALUOP_W-1:0] aluop_q, aluop_d;
    logic               alusrc_q, alusrc_d;
    logic               regwrite_q, regwrite_d;
    logic               memread_q, memread_d;
    logic               memwrite_q, memwrite_d;
    logic [CNT_W-1:0]   bubble_q, bubble_d;

    logic hz;
    logic hz_load_use;
    logic rt_used;
    logic [31:0] fwd_rs, fwd_rt;

    assign ex_valid    = valid_q;
    assign ex_regwrite = valid_q & regwrite_q;
    assign ex_memread  = valid_q & memread_q;
    assign ex_memwrite = valid_q & memwrite_q;
    assign alu_op      = aluop_q;
    assign ex_rd       = rd_q;
    assign bubble_cnt  = bubble_q;

    // rt is a real source for R-type ops and for stores (store data), not for plain I-type.
    assign rt_used = ~id_alusrc | id_memwrite;

    assign hz_load_use = ex_memread & (rd_q != 5'd0) & id_valid &
                         ((rd_q == id_rs) | ((rd_q == id_rt) & rt_used));

`ifdef IDEX_FWD_EN
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  s,
        input logic [31:0] reg_data,
        input logic        em_we,
        input logic [4:0]  em_rd,
        input logic [31:0] em_res,
        input logic        mw_we,
        input logic [4:0]  mw_rd,
        input logic [31:0] mw_res
    );
        logic [31:0] r;
        r = reg_data;
        if (s != 5'd0) begin
            if (em_we && em_rd == s)      r = em_res;
            else if (mw_we && mw_rd == s) r = mw_res;
        end
        return r;
    endfunction

    always_comb begin
        fwd_rs = fwd_sel(rs_q, rs_data_q, exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result);
        fwd_rt = fwd_sel(rt_q, rt_data_q, exmem_regwrite, exmem_rd, exmem_result,
                         memwb_regwrite, memwb_rd, memwb_result);
    end

    assign hz = hz_load_use;
`else
    logic rs_dep, rt_dep;
    logic unused_nofwd;

    // Without forwarding, wait until the producer has left EX/MEM; the register file
    // is write-through so a producer in MEM/WB is already visible.
    always_comb begin
        rs_dep = (id_rs != 5'd0) &
                 ((ex_regwrite & (rd_q == id_rs)) | (exmem_regwrite & (exmem_rd == id_rs)));
        rt_dep = rt_used & (id_rt != 5'd0) &
                 ((ex_regwrite & (rd_q == id_rt)) | (exmem_regwrite & (exmem_rd == id_rt)));
    end

    assign hz           = hz_load_use | (id_valid & (rs_dep | rt_dep));
    assign fwd_rs       = rs_data_q;
    assign fwd_rt       = rt_data_q;
    assign unused_nofwd = ^{rs_q, rt_q, exmem_result, memwb_regwrite, memwb_rd, memwb_result};
`endif

    assign id_stall      = hz | ext_hold;
    assign alu_a         = fwd_rs;
    assign alu_b         = alusrc_q ? imm_q : fwd_rt;
    assign ex_store_data = fwd_rt;

    always_comb begin
        valid_d    = valid_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        rs_data_d  = rs_data_q;
        rt_data_d  = rt_data_q;
        imm_d      = imm_q;
        aluop_d    = aluop_q;
        alusrc_d   = alusrc_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        memwrite_d = memwrite_q;
        bubble_d   = bubble_q;
        if (ext_hold) begin
            valid_d = valid_q;
        end else if (flush) begin
            valid_d = 1'b0;
        end else if (hz) begin
            valid_d  = 1'b0;
            bubble_d = bubble_q + CNT_W'(1);
        end else begin
            valid_d    = id_valid;
            rs_d       = id_rs;
            rt_d       = id_rt;
            rd_d       = id_rd;
            rs_data_d  = id_rs_data;
            rt_data_d  = id_rt_data;
            imm_d      = id_imm;
            aluop_d    = id_aluop;
            alusrc_d   = id_alusrc;
            regwrite_d = id_regwrite;
            memread_d  = id_memread;
            memwrite_d = id_memwrite;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q    <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            rs_data_q  <= '0;
            rt_data_q  <= '0;
            imm_q      <= '0;
            aluop_q    <= '0;
            alusrc_q   <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            bubble_q   <= '0;
        end else begin
            valid_q    <= valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            rs_data_q  <= rs_data_d;
            rt_data_q  <= rt_data_d;
            imm_q      <= imm_d;
            aluop_q    <= aluop_d;
            alusrc_q   <= alusrc_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            bubble_q   <= bubble_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding (or stalls when
// IDEX_FWD_EN is undefined), load-use bubbles and hold/flush/hazard priority.
module tb_id_ex_stage;

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_aluop;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite;
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        ext_hold, flush;
    logic        id_stall, ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [4:0]  alu_op, ex_rd;
    logic        ex_regwrite, ex_memread, ex_memwrite;
    logic [31:0] bubble_cnt;

    int test_cnt = 0;
    int fail_cnt = 0;
    int exp_bub  = 0;

    id_ex_stage #(.ALUOP_W(5), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_aluop(id_aluop), .id_alusrc(id_alusrc), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .ext_hold(ext_hold), .flush(flush), .id_stall(id_stall), .ex_valid(ex_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .ex_memwrite(ex_memwrite), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic present(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd,
                           input logic [31:0] imm, input logic [4:0] op, input logic src,
                           input logic rw, input logic mr, input logic mw);
        id_valid = v;    id_rs = rs;       id_rt = rt;        id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;     id_aluop = op;
        id_alusrc = src; id_regwrite = rw; id_memread = mr;   id_memwrite = mw;
    endtask

    task automatic bus(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                       input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
        exmem_regwrite = ew; exmem_rd = erd; exmem_result = eres;
        memwb_regwrite = mw; memwb_rd = mrd; memwb_result = mres;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; ext_hold = 1'b0; flush = 1'b0;
        bus(0, 0, 0, 0, 0, 0);
        present(1, 1, 2, 3, 32'h11, 32'h22, 0, 2, 0, 1, 0, 0);
        tick(); tick();
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_regwrite", ex_regwrite, 0);
        chk("rst_bubble", bubble_cnt, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_ex_rd", ex_rd, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_stall", id_stall, 0);
        rstn = 1'b1;

        // ADDI r2, r1, 5
        present(1, 1, 2, 2, 32'h11, 32'h22, 32'h5, 1, 1, 1, 0, 0);
        settle();
        chk("addi_stall", id_stall, 0);
        tick();
        chk("addi_valid", ex_valid, 1);
        chk("addi_alu_a", alu_a, 32'h11);
        chk("addi_alu_b", alu_b, 32'h5);
        chk("addi_store", ex_store_data, 32'h22);
        chk("addi_op", alu_op, 1);
        chk("addi_rd", ex_rd, 2);
        chk("addi_rw", ex_regwrite, 1);
        chk("addi_mr", ex_memread, 0);

        // ADD r4, r2, r1 directly after the ADDI
        present(1, 2, 1, 4, 32'h33, 32'h44, 0, 2, 0, 1, 0, 0);
        settle();
`ifdef IDEX_FWD_EN
        chk("dep_stall", id_stall, 0);
        tick();
        chk("dep_valid", ex_valid, 1);
        chk("dep_rd", ex_rd, 4);
        id_valid = 1'b0;
        bus(1, 2, 32'h10, 1, 2, 32'h20);
        settle();
        chk("fwd_exmem", alu_a, 32'h10);
        chk("fwd_b_none", alu_b, 32'h44);
        bus(0, 2, 32'h10, 1, 2, 32'h20);
        settle();
        chk("fwd_memwb", alu_a, 32'h20);
        bus(0, 0, 0, 1, 1, 32'h55);
        settle();
        chk("fwd_rt_b", alu_b, 32'h55);
        chk("fwd_rt_store", ex_store_data, 32'h55);
        bus(0, 0, 0, 0, 0, 0);
        settle();
        chk("fwd_none", alu_a, 32'h33);
`else
        chk("dep_stall_ex", id_stall, 1);
        tick();
        exp_bub++;
        chk("dep_bubble1_valid", ex_valid, 0);
        chk("dep_bubble1_cnt", bubble_cnt, exp_bub);
        bus(1, 2, 32'h10, 0, 0, 0);
        settle();
        chk("dep_stall_exmem", id_stall, 1);
        tick();
        exp_bub++;
        chk("dep_bubble2_valid", ex_valid, 0);
        chk("dep_bubble2_cnt", bubble_cnt, exp_bub);
        bus(0, 0, 0, 0, 0, 0);
        settle();
        chk("dep_stall_clear", id_stall, 0);
        tick();
        chk("dep_valid", ex_valid, 1);
        chk("dep_rd", ex_rd, 4);
        id_valid = 1'b0;
        bus(1, 2, 32'h10, 1, 2, 32'h20);
        settle();
        chk("nofwd_a", alu_a, 32'h33);
        chk("nofwd_b", alu_b, 32'h44);
        bus(0, 0, 0, 0, 0, 0);
`endif

        // idle ID -> bubble; operands stay stale, control is zero
        id_valid = 1'b0;
        tick();
        chk("idle_valid", ex_valid, 0);
        chk("idle_rw", ex_regwrite, 0);
        chk("idle_stale_a", alu_a, 32'h33);
        chk("idle_cnt", bubble_cnt, exp_bub);

        // rs = r0 never forwards
        present(1, 0, 0, 5, 0, 0, 0, 2, 0, 1, 0, 0);
        tick();
        bus(1, 0, 32'h10, 1, 0, 32'h20);
        settle();
        chk("r0_alu_a", alu_a, 0);
        chk("r0_alu_b", alu_b, 0);
        bus(0, 0, 0, 0, 0, 0);

        // store with immediate, rt produced in MEM/WB
        present(1, 0, 7, 0, 0, 32'h77, 32'hFFFF_FFFC, 3, 1, 0, 0, 1);
        settle();
        chk("sw_stall", id_stall, 0);
        tick();
        bus(0, 0, 0, 1, 7, 32'hAB);
        settle();
        chk("sw_alu_b", alu_b, 32'hFFFF_FFFC);
        chk("sw_memwrite", ex_memwrite, 1);
        chk("sw_regwrite", ex_regwrite, 0);
`ifdef IDEX_FWD_EN
        chk("sw_store", ex_store_data, 32'hAB);
`else
        chk("sw_store", ex_store_data, 32'h77);
`endif
        bus(0, 0, 0, 0, 0, 0);

        // LW r5 then ADD r6, r5, r1
        present(1, 1, 5, 5, 32'h100, 0, 32'h8, 0, 1, 1, 1, 0);
        tick();
        chk("lw_memread", ex_memread, 1);
        present(1, 5, 1, 6, 32'h55, 32'h66, 0, 2, 0, 1, 0, 0);
        settle();
        chk("lu_stall", id_stall, 1);
        tick();
        exp_bub++;
        chk("lu_valid", ex_valid, 0);
        chk("lu_cnt", bubble_cnt, exp_bub);
        chk("lu_memread", ex_memread, 0);
        settle();
        chk("lu_stall_clear", id_stall, 0);
        tick();
        chk("lu_cap_valid", ex_valid, 1);
        chk("lu_cap_rd", ex_rd, 6);
        chk("lu_cap_a", alu_a, 32'h55);
        chk("lu_cap_b", alu_b, 32'h66);

        // flush wins over hazard: no count
        present(1, 1, 5, 5, 32'h100, 0, 32'h8, 0, 1, 1, 1, 0);
        tick();
        present(1, 5, 1, 6, 32'h55, 32'h66, 0, 2, 0, 1, 0, 0);
        flush = 1'b1;
        settle();
        chk("fl_stall", id_stall, 1);
        tick();
        flush = 1'b0;
        chk("fl_valid", ex_valid, 0);
        chk("fl_cnt", bubble_cnt, exp_bub);
        settle();
        chk("fl_stall_clear", id_stall, 0);
        tick();
        chk("fl_cap_valid", ex_valid, 1);

        // ext_hold wins over flush and hazard: everything frozen
        present(1, 1, 5, 5, 32'h100, 0, 32'h8, 0, 1, 1, 1, 0);
        tick();
        chk("hold_lw_rd", ex_rd, 5);
        present(1, 5, 1, 6, 32'h55, 32'h66, 0, 2, 0, 1, 0, 0);
        ext_hold = 1'b1;
        flush = 1'b1;
        settle();
        chk("hold_stall", id_stall, 1);
        tick(); tick();
        chk("hold_valid", ex_valid, 1);
        chk("hold_memread", ex_memread, 1);
        chk("hold_rd", ex_rd, 5);
        chk("hold_op", alu_op, 0);
        chk("hold_a", alu_a, 32'h100);
        chk("hold_cnt", bubble_cnt, exp_bub);
        ext_hold = 1'b0;
        flush = 1'b0;
        settle();
        chk("unhold_stall", id_stall, 1);
        tick();
        exp_bub++;
        chk("unhold_valid", ex_valid, 0);
        chk("unhold_cnt", bubble_cnt, exp_bub);
        tick();
        chk("unhold_cap_rd", ex_rd, 6);
        chk("unhold_cap_valid", ex_valid, 1);

        // synchronous reset overrides ext_hold
        ext_hold = 1'b1;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        ext_hold = 1'b0;
        chk("rst2_valid", ex_valid, 0);
        chk("rst2_cnt", bubble_cnt, 0);
        chk("rst2_op", alu_op, 0);
        chk("rst2_a", alu_a, 0);
        chk("rst2_rd", ex_rd, 0);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
